// File: rtl/coffee_dispense_ctrl.sv
// coffee_dispense_ctrl
// Runs the dispensing sequence for one paid order: cup drop, wait for the cup,
// powder, then water/pump for a time set by the coffee type. While busy it
// holds one pending order. Cup loss or cup timeout latches a fault.
module coffee_dispense_ctrl #(
  parameter int CNT_W      = 8,
  parameter int CUP_CYC    = 4,
  parameter int CUP_TMO    = 20,
  parameter int POWDER_CYC = 8,
  parameter int WATER_BASE = 16,
  parameter int WATER_STEP = 8
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       vend_req,
  input  logic [1:0] coffee_sel,
  input  logic       cup_present,
  input  logic       fault_clr,
  output logic       cup_drop,
  output logic       powder_motor,
  output logic       water_valve,
  output logic       pump_on,
  output logic       vend_done,
  output logic       vend_drop,
  output logic       busy,
  output logic       LED_Yellow,
  output logic       LED_Green,
  output logic       fault
);

  localparam logic [2:0] S_IDLE     = 3'd0;
  localparam logic [2:0] S_CUP      = 3'd1;
  localparam logic [2:0] S_WAIT_CUP = 3'd2;
  localparam logic [2:0] S_POWDER   = 3'd3;
  localparam logic [2:0] S_WATER    = 3'd4;
  localparam logic [2:0] S_DONE     = 3'd5;
  localparam logic [2:0] S_FAULT    = 3'd6;

  // The phase counter is loaded with (duration - 1) when a phase starts.
  localparam logic [CNT_W-1:0] CUP_LOAD    = CNT_W'(CUP_CYC - 1);
  localparam logic [CNT_W-1:0] TMO_LOAD    = CNT_W'(CUP_TMO - 1);
  localparam logic [CNT_W-1:0] POWDER_LOAD = CNT_W'(POWDER_CYC - 1);

  logic [2:0]       state_reg, state_next;
  logic [CNT_W-1:0] cnt_reg, cnt_next;
  logic [1:0]       cur_sel_reg, cur_sel_next;
  logic [1:0]       pend_sel_reg, pend_sel_next;
  logic             pend_valid_reg, pend_valid_next;
  logic             vend_drop_reg, vend_drop_next;

  logic [CNT_W+1:0] water_sum;
  logic [CNT_W-1:0] water_len;
  logic [CNT_W-1:0] water_load;
  logic [CNT_W-1:0] cnt_dec;

  // Water duration for the current order; two guard bits catch overflow so
  // the result can saturate instead of wrapping.
  always_comb begin
    water_sum  = (CNT_W+2)'(WATER_BASE)
               + (CNT_W+2)'(cur_sel_reg) * (CNT_W+2)'(WATER_STEP);
    water_len  = (|water_sum[CNT_W+1:CNT_W]) ? '1 : water_sum[CNT_W-1:0];
    water_load = (water_len == '0) ? '0 : water_len - CNT_W'(1);
    cnt_dec    = cnt_reg - CNT_W'(1);
  end

  // Next-state, phase counter, order selection and pending-slot logic.
  always_comb begin
    state_next      = state_reg;
    cnt_next        = cnt_reg;
    cur_sel_next    = cur_sel_reg;
    pend_sel_next   = pend_sel_reg;
    pend_valid_next = pend_valid_reg;
    vend_drop_next  = 1'b0;

    // Orders arriving while busy go to the single pending slot, or are
    // rejected when the slot is taken or the machine is faulted.
    if (vend_req && state_reg != S_IDLE) begin
      if (state_reg != S_FAULT && !pend_valid_reg) begin
        pend_valid_next = 1'b1;
        pend_sel_next   = coffee_sel;
      end else begin
        vend_drop_next  = 1'b1;
      end
    end

    case (state_reg)
      S_IDLE: begin
        if (vend_req) begin
          cur_sel_next = coffee_sel;
          state_next   = S_CUP;
          cnt_next     = CUP_LOAD;
        end
      end
      S_CUP: begin
        if (cnt_reg == '0) begin
          state_next = S_WAIT_CUP;
          cnt_next   = TMO_LOAD;
        end else begin
          cnt_next = cnt_dec;
        end
      end
      S_WAIT_CUP: begin
        if (cup_present) begin
          state_next = S_POWDER;
          cnt_next   = POWDER_LOAD;
        end else if (cnt_reg == '0) begin
          state_next = S_FAULT;
          cnt_next   = '0;
        end else begin
          cnt_next = cnt_dec;
        end
      end
      S_POWDER: begin
        if (!cup_present) begin
          state_next = S_FAULT;
          cnt_next   = '0;
        end else if (cnt_reg == '0) begin
          state_next = S_WATER;
          cnt_next   = water_load;
        end else begin
          cnt_next = cnt_dec;
        end
      end
      S_WATER: begin
        if (!cup_present) begin
          state_next = S_FAULT;
          cnt_next   = '0;
        end else if (cnt_reg == '0) begin
          state_next = S_DONE;
          cnt_next   = '0;
        end else begin
          cnt_next = cnt_dec;
        end
      end
      S_DONE: begin
        // A request arriving in this very cycle is treated as if it had been
        // latched in the slot, so it starts straight away.
        if (pend_valid_reg) begin
          cur_sel_next    = pend_sel_reg;
          pend_valid_next = 1'b0;
          state_next      = S_CUP;
          cnt_next        = CUP_LOAD;
        end else if (vend_req) begin
          cur_sel_next    = coffee_sel;
          pend_valid_next = 1'b0;
          state_next      = S_CUP;
          cnt_next        = CUP_LOAD;
        end else begin
          state_next = S_IDLE;
        end
      end
      S_FAULT: begin
        if (fault_clr) begin
          state_next = S_IDLE;
        end
      end
      default: begin
        state_next = S_IDLE;
        cnt_next   = '0;
      end
    endcase

    // Any entry into FAULT discards the queued order as well.
    if (state_next == S_FAULT && state_reg != S_FAULT) begin
      pend_valid_next = 1'b0;
    end
  end

  // State registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg      <= S_IDLE;
      cnt_reg        <= '0;
      cur_sel_reg    <= 2'd0;
      pend_sel_reg   <= 2'd0;
      pend_valid_reg <= 1'b0;
      vend_drop_reg  <= 1'b0;
    end else begin
      state_reg      <= state_next;
      cnt_reg        <= cnt_next;
      cur_sel_reg    <= cur_sel_next;
      pend_sel_reg   <= pend_sel_next;
      pend_valid_reg <= pend_valid_next;
      vend_drop_reg  <= vend_drop_next;
    end
  end

  // Moore outputs decoded from the registered state.
  always_comb begin
    cup_drop     = (state_reg == S_CUP);
    powder_motor = (state_reg == S_POWDER);
    water_valve  = (state_reg == S_WATER);
    pump_on      = (state_reg == S_WATER);
    vend_done    = (state_reg == S_DONE);
    busy         = (state_reg != S_IDLE) && (state_reg != S_FAULT);
    LED_Yellow   = busy;
    LED_Green    = (state_reg == S_IDLE);
    fault        = (state_reg == S_FAULT);
    vend_drop    = vend_drop_reg;
  end

endmodule

// File: tb/tb_coffee_dispense_ctrl.sv
// Directed testbench for coffee_dispense_ctrl with hand-computed timings
// for the default parameters.
module tb_coffee_dispense_ctrl;

  logic       clk = 1'b0;
  logic       rst;
  logic       vend_req;
  logic [1:0] coffee_sel;
  logic       cup_present;
  logic       fault_clr;
  logic       cup_drop, powder_motor, water_valve, pump_on;
  logic       vend_done, vend_drop, busy, LED_Yellow, LED_Green, fault;

  int checks = 0;
  int errors = 0;

  // Per-scenario observation counters; off is the cycle index relative to
  // the edge that sampled the first vend_req of the scenario.
  int off, n_cup, n_wait, n_pow, n_wat, n_pump, n_drop, n_done, done_at, fault_at;

  int exp_wat [4] = '{16, 24, 32, 40};
  int exp_done[4] = '{30, 38, 46, 54};

  coffee_dispense_ctrl dut (
    .clk          (clk),
    .rst          (rst),
    .vend_req     (vend_req),
    .coffee_sel   (coffee_sel),
    .cup_present  (cup_present),
    .fault_clr    (fault_clr),
    .cup_drop     (cup_drop),
    .powder_motor (powder_motor),
    .water_valve  (water_valve),
    .pump_on      (pump_on),
    .vend_done    (vend_done),
    .vend_drop    (vend_drop),
    .busy         (busy),
    .LED_Yellow   (LED_Yellow),
    .LED_Green    (LED_Green),
    .fault        (fault)
  );

  always #5 clk = ~clk;

  task automatic check_val(input string tag, input int got, input int exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end else begin
      $display("ok   %s = %0d", tag, got);
    end
  endtask

  task automatic clear_counts();
    off = 0; n_cup = 0; n_wait = 0; n_pow = 0; n_wat = 0; n_pump = 0;
    n_drop = 0; n_done = 0; done_at = -1; fault_at = -1;
  endtask

  // Advance one cycle and sample outputs 1 time unit after the edge.
  task automatic step();
    @(posedge clk);
    #1;
    off++;
    n_cup  += int'(cup_drop);
    n_pow  += int'(powder_motor);
    n_wat  += int'(water_valve);
    n_pump += int'(pump_on);
    n_drop += int'(vend_drop);
    if (vend_done) begin
      n_done++;
      done_at = off;
    end
    if (busy && !cup_drop && !powder_motor && !water_valve && !vend_done) n_wait++;
    if (fault && fault_at < 0) fault_at = off;
  endtask

  task automatic adv_to(input int target);
    while (off < target) step();
  endtask

  task automatic pulse_req(input logic [1:0] sel);
    vend_req   = 1'b1;
    coffee_sel = sel;
    step();
    vend_req   = 1'b0;
  endtask

  task automatic start_order(input logic [1:0] sel);
    clear_counts();
    pulse_req(sel);
  endtask

  initial begin
    rst = 1'b1; vend_req = 1'b0; coffee_sel = 2'd0; cup_present = 1'b1; fault_clr = 1'b0;
    clear_counts();
    step(); step();
    rst = 1'b0;
    step();

    // Reset state
    check_val("rst_led_green", int'(LED_Green), 1);
    check_val("rst_busy", int'(busy), 0);
    check_val("rst_led_yellow", int'(LED_Yellow), 0);
    check_val("rst_actuators", int'({cup_drop, powder_motor, water_valve, pump_on}), 0);
    check_val("rst_fault_done_drop", int'({fault, vend_done, vend_drop}), 0);

    // Single orders, all four coffee types, cup already present
    for (int s = 0; s < 4; s++) begin
      start_order(2'(s));
      adv_to(exp_done[s] + 2);
      check_val($sformatf("sel%0d_cup_cycles", s), n_cup, 4);
      check_val($sformatf("sel%0d_wait_cycles", s), n_wait, 1);
      check_val($sformatf("sel%0d_powder_cycles", s), n_pow, 8);
      check_val($sformatf("sel%0d_water_cycles", s), n_wat, exp_wat[s]);
      check_val($sformatf("sel%0d_pump_cycles", s), n_pump, exp_wat[s]);
      check_val($sformatf("sel%0d_done_count", s), n_done, 1);
      check_val($sformatf("sel%0d_done_at", s), done_at, exp_done[s]);
      check_val($sformatf("sel%0d_idle_green", s), int'(LED_Green), 1);
    end

    // Cup never arrives: timeout to FAULT after 20 WAIT_CUP cycles
    cup_present = 1'b0;
    start_order(2'd0);
    adv_to(26);
    check_val("tmo_wait_cycles", n_wait, 20);
    check_val("tmo_fault_at", fault_at, 25);
    check_val("tmo_fault", int'(fault), 1);
    check_val("tmo_actuators", int'({cup_drop, powder_motor, water_valve, pump_on}), 0);
    check_val("tmo_busy", int'(busy), 0);
    check_val("tmo_green", int'(LED_Green), 0);
    pulse_req(2'd2);
    check_val("fault_req_drop", int'(vend_drop), 1);
    step();
    check_val("fault_drop_one_cycle", int'(vend_drop), 0);
    fault_clr = 1'b1;
    step();
    fault_clr = 1'b0;
    cup_present = 1'b1;
    check_val("clr_green", int'(LED_Green), 1);
    check_val("clr_fault", int'(fault), 0);

    // Cup lost in WATER cycle 5 with an order pending
    start_order(2'd0);
    adv_to(7);
    pulse_req(2'd3);
    adv_to(18);
    check_val("loss_water_before", int'(water_valve), 1);
    cup_present = 1'b0;
    step();
    cup_present = 1'b1;
    check_val("loss_actuators", int'({cup_drop, powder_motor, water_valve, pump_on}), 0);
    check_val("loss_fault", int'(fault), 1);
    fault_clr = 1'b1;
    step();
    fault_clr = 1'b0;
    step(); step(); step();
    check_val("loss_no_done", n_done, 0);
    check_val("loss_slot_cleared_idle", int'(LED_Green), 1);
    check_val("loss_no_new_cup", n_cup, 4);

    // A (sel 1), B queued during POWDER (sel 2), C dropped during WATER
    start_order(2'd1);
    adv_to(7);
    pulse_req(2'd2);
    adv_to(20);
    pulse_req(2'd3);
    check_val("abc_c_drop", int'(vend_drop), 1);
    adv_to(38);
    check_val("abc_a_done", int'(vend_done), 1);
    step();
    check_val("abc_b_cup_next", int'(cup_drop), 1);
    check_val("abc_no_idle_gap", int'(LED_Green), 0);
    adv_to(86);
    check_val("abc_b_done_at", done_at, 84);
    check_val("abc_done_count", n_done, 2);
    check_val("abc_water_total", n_wat, 56);
    check_val("abc_drop_count", n_drop, 1);
    check_val("abc_idle_after", int'(LED_Green), 1);

    // vend_req exactly in DONE with the slot empty starts the next order
    start_order(2'd0);
    adv_to(30);
    check_val("dreq_done", int'(vend_done), 1);
    pulse_req(2'd1);
    check_val("dreq_cup_next", int'(cup_drop), 1);
    check_val("dreq_no_drop", int'(vend_drop), 0);
    adv_to(72);
    check_val("dreq_second_done_at", done_at, 68);
    check_val("dreq_water_total", n_wat, 40);

    // Reset mid-WATER with an order pending
    start_order(2'd0);
    pulse_req(2'd2);
    adv_to(20);
    check_val("mrst_in_water", int'(water_valve), 1);
    rst = 1'b1;
    step();
    rst = 1'b0;
    check_val("mrst_actuators", int'({cup_drop, powder_motor, water_valve, pump_on}), 0);
    check_val("mrst_green", int'(LED_Green), 1);
    check_val("mrst_busy", int'(busy), 0);
    step(); step(); step();
    check_val("mrst_slot_empty_idle", int'(LED_Green), 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
